// File: rtl/booth_r4_seq_mul.sv
// Iterative radix-4 Booth multiplier.
// Retires one Booth digit per clock through a single partial-product adder.
// Supports signed and unsigned operands, with valid/ready handshakes on both sides.
// The product stays registered until the consumer takes it.
module booth_r4_seq_mul #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int STEPS = WIDTH / 2 + 1;
    localparam int CW    = $clog2(STEPS) + 1;
    localparam int MW    = WIDTH + 2;
    localparam int AW    = 2 * WIDTH + 4;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [MW-1:0]    r_mcand;
    logic [MW:0]      r_window;
    logic [AW-1:0]    r_acc;
    logic [CW-1:0]    r_count;

    logic             w_accept;
    logic             w_lastStep;
    logic [MW-1:0]    w_aExt;
    logic [MW-1:0]    w_bExt;
    logic [AW-1:0]    w_mcandExt;
    logic [AW-1:0]    w_partial;
    logic [AW-1:0]    w_shifted;

    // Two extra bits let the unsigned all-ones case produce its final positive digit.
    assign w_aExt     = is_signed ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
    assign w_bExt     = is_signed ? {{2{b[WIDTH-1]}}, b} : {2'b00, b};
    assign w_mcandExt = {{(AW-MW){r_mcand[MW-1]}}, r_mcand};
    assign w_lastStep = (r_count == CW'(STEPS - 1));
    assign w_shifted  = w_partial << {r_count, 1'b0};

    // Recode the low three window bits into a digit times the multiplicand.
    always_comb begin
        w_partial = '0;
        case (r_window[2:0])
            3'b001, 3'b010: w_partial = w_mcandExt;
            3'b011:         w_partial = w_mcandExt << 1;
            3'b100:         w_partial = -(w_mcandExt << 1);
            3'b101, 3'b110: w_partial = -w_mcandExt;
            default:        w_partial = '0;
        endcase
    end

    // Next-state and handshake outputs; reset masks every output immediately.
    always_comb begin
        w_nextState = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        product     = '0;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                w_accept = in_valid;
                if (in_valid) w_nextState = CALC;
            end
            CALC: begin
                busy = 1'b1;
                if (w_lastStep) w_nextState = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                product   = r_acc[2*WIDTH-1:0];
                if (out_ready) w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
        if (rst) begin
            in_ready    = 1'b0;
            out_valid   = 1'b0;
            busy        = 1'b0;
            product     = '0;
            w_accept    = 1'b0;
            w_nextState = IDLE;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_nextState;
    end

    // Datapath: latch operands on accept, then perform one Booth step per CALC cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand  <= '0;
            r_window <= '0;
            r_acc    <= '0;
            r_count  <= '0;
        end else if (w_accept) begin
            r_mcand  <= w_aExt;
            r_window <= {w_bExt, 1'b0};
            r_acc    <= '0;
            r_count  <= '0;
        end else if (r_state == CALC) begin
            r_acc    <= r_acc + w_shifted;
            r_window <= {{2{r_window[MW]}}, r_window[MW:2]};
            r_count  <= r_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_booth_r4_seq_mul.sv
// Self-checking bench for booth_r4_seq_mul at WIDTH=8 and WIDTH=16.
// The expected products come from plain integer multiplication of the operands.
module tb_booth_r4_seq_mul;

    localparam int STEPS8  = 5;
    localparam int STEPS16 = 9;

    logic        clk = 1'b0;
    logic        rst;

    logic        inValid8, inReady8, signed8, outValid8, outReady8, busy8;
    logic [7:0]  a8, b8;
    logic [15:0] product8;

    logic        inValid16, inReady16, signed16, outValid16, outReady16, busy16;
    logic [15:0] a16, b16;
    logic [31:0] product16;

    int compareCount = 0;
    int failCount    = 0;

    booth_r4_seq_mul #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(inValid8), .in_ready(inReady8),
        .a(a8), .b(b8), .is_signed(signed8), .out_valid(outValid8),
        .out_ready(outReady8), .product(product8), .busy(busy8)
    );

    booth_r4_seq_mul #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(inValid16), .in_ready(inReady16),
        .a(a16), .b(b16), .is_signed(signed16), .out_valid(outValid16),
        .out_ready(outReady16), .product(product16), .busy(busy16)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Reference product: interpret operands as integers and multiply.
    function automatic logic [31:0] refMul(input logic [15:0] ta, input logic [15:0] tb,
                                           input logic ts, input int w);
        longint x, y, p, mask;
        x = longint'(ta);
        y = longint'(tb);
        if (ts && ta[w-1]) x = x - (longint'(1) << w);
        if (ts && tb[w-1]) y = y - (longint'(1) << w);
        p    = x * y;
        mask = (longint'(1) << (2 * w)) - 1;
        p    = p & mask;
        return p[31:0];
    endfunction

    // Single comparison point.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        compareCount++;
        assert (got === want) else begin
            failCount++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, got, want);
        end
    endtask

    // One 8-bit transaction with an optional output stall; entered and left #1 after an edge.
    task automatic applyStimulus(input logic [7:0] ta, input logic [7:0] tb, input logic ts,
                                 input int stall, input string tag);
        logic [31:0] expected;
        int lat;
        expected = refMul({8'h00, ta}, {8'h00, tb}, ts, 8);
        checkOutput({tag, "/inReady"}, 32'(inReady8), 32'd1);
        inValid8  = 1'b1;
        a8        = ta;
        b8        = tb;
        signed8   = ts;
        outReady8 = (stall == 0);
        @(posedge clk); #1;
        inValid8 = 1'b0;
        a8       = 8'($urandom);
        b8       = 8'($urandom);
        signed8  = 1'($urandom);
        checkOutput({tag, "/busy"}, 32'(busy8), 32'd1);
        lat = 0;
        while (outValid8 !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput({tag, "/latency"}, 32'(lat), 32'(STEPS8));
        checkOutput({tag, "/product"}, 32'(product8), {16'h0000, expected[15:0]});
        for (int i = 0; i < stall; i++) begin
            inValid8 = (i == 2);
            a8       = 8'($urandom);
            b8       = 8'($urandom);
            @(posedge clk); #1;
            checkOutput({tag, "/holdValid"}, 32'(outValid8), 32'd1);
            checkOutput({tag, "/holdProduct"}, 32'(product8), {16'h0000, expected[15:0]});
            checkOutput({tag, "/holdInReady"}, 32'(inReady8), 32'd0);
        end
        inValid8  = 1'b0;
        outReady8 = 1'b1;
        @(posedge clk); #1;
        checkOutput({tag, "/releaseValid"}, 32'(outValid8), 32'd0);
        checkOutput({tag, "/releaseInReady"}, 32'(inReady8), 32'd1);
        checkOutput({tag, "/releaseBusy"}, 32'(busy8), 32'd0);
        checkOutput({tag, "/releaseProduct"}, 32'(product8), 32'd0);
        outReady8 = 1'b0;
    endtask

    // One 16-bit transaction with the consumer always ready.
    task automatic applyStimulus16(input logic [15:0] ta, input logic [15:0] tb, input logic ts,
                                   input string tag);
        logic [31:0] expected;
        int lat;
        expected = refMul(ta, tb, ts, 16);
        checkOutput({tag, "/inReady"}, 32'(inReady16), 32'd1);
        inValid16  = 1'b1;
        a16        = ta;
        b16        = tb;
        signed16   = ts;
        outReady16 = 1'b1;
        @(posedge clk); #1;
        inValid16 = 1'b0;
        a16       = 16'($urandom);
        b16       = 16'($urandom);
        lat = 0;
        while (outValid16 !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput({tag, "/latency"}, 32'(lat), 32'(STEPS16));
        checkOutput({tag, "/product"}, product16, expected);
        @(posedge clk); #1;
        checkOutput({tag, "/releaseValid"}, 32'(outValid16), 32'd0);
        outReady16 = 1'b0;
    endtask

    // Directed steps followed by a randomized sweep.
    initial begin
        rst = 1'b1;
        inValid8 = 1'b0;  a8 = '0;  b8 = '0;  signed8 = 1'b0;  outReady8 = 1'b0;
        inValid16 = 1'b0; a16 = '0; b16 = '0; signed16 = 1'b0; outReady16 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst/inReady", 32'(inReady8), 32'd0);
        checkOutput("rst/outValid", 32'(outValid8), 32'd0);
        checkOutput("rst/busy", 32'(busy8), 32'd0);
        checkOutput("rst/product", 32'(product8), 32'd0);
        checkOutput("rst/inReady16", 32'(inReady16), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("postRst/inReady", 32'(inReady8), 32'd1);

        applyStimulus(8'h15, 8'hAF, 1'b1, 0, "s15xAF");
        checkOutput("const/F95B", refMul(16'h0015, 16'h00AF, 1'b1, 8), 32'h0000F95B);
        applyStimulus(8'hB5, 8'h2E, 1'b1, 0, "sB5x2E");
        applyStimulus(8'hFF, 8'hFF, 1'b0, 0, "uFFxFF");
        applyStimulus(8'hFF, 8'hFF, 1'b1, 0, "sFFxFF");
        applyStimulus(8'h80, 8'h80, 1'b1, 0, "s80x80");
        applyStimulus(8'h00, 8'hA5, 1'b1, 0, "zeroA");
        applyStimulus(8'h5A, 8'h00, 1'b0, 0, "zeroB");
        applyStimulus(8'h15, 8'hAF, 1'b1, 10, "stall10");

        $display("[TB] reset in the middle of a calculation");
        inValid8 = 1'b1; a8 = 8'h7F; b8 = 8'h7F; signed8 = 1'b1;
        @(posedge clk); #1;
        inValid8 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checkOutput("midRst/inReadyDuring", 32'(inReady8), 32'd0);
        checkOutput("midRst/busyDuring", 32'(busy8), 32'd0);
        @(posedge clk); #1;
        checkOutput("midRst/busy", 32'(busy8), 32'd0);
        checkOutput("midRst/outValid", 32'(outValid8), 32'd0);
        checkOutput("midRst/product", 32'(product8), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        applyStimulus(8'h03, 8'hFD, 1'b1, 0, "s03xFD");

        applyStimulus16(16'h8000, 16'h7FFF, 1'b1, "w16s8000x7FFF");
        applyStimulus16(16'hFFFF, 16'h0002, 1'b0, "w16uFFFFx0002");
        applyStimulus16(16'hFFFF, 16'hFFFF, 1'b0, "w16uFFFFxFFFF");
        applyStimulus16(16'h8000, 16'h8000, 1'b1, "w16s8000x8000");
        for (int i = 0; i < 20; i++) begin
            applyStimulus16(16'($urandom), 16'($urandom), 1'($urandom), "w16rand");
        end

        $display("[TB] random sweep");
        for (int i = 0; i < 1000; i++) begin
            applyStimulus(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule

// File: doc/booth_r4_seq_mul.md
Name: booth_r4_seq_mul

Overview:
- Parametrised, iterative radix-4 Booth multiplier; successor to the fixed 8-bit combinational Booth/RCA multiplier.
- Retires one Booth digit per clock, so a single partial-product adder replaces the adder tree.
- Adds a signed/unsigned mode, valid/ready handshakes on both sides, and a registered result held until consumed.
- Sits between the operand source and any downstream accumulator in the arithmetic datapath.

Parameters:
- WIDTH, 8, operand width in bits; must be even and >= 4.
- STEPS, WIDTH/2+1, derived (localparam, not overridable); number of Booth digits processed per operation.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands a, b, is_signed valid this cycle.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with a/b.
- out_valid  output  1  product valid.
- out_ready  input  1  consumer accepts product.
- product  output  2*WIDTH  a*b, full width, no truncation.
- busy  output  1  high in CALC or DONE.

Behaviour:
- Reset: a synchronous rst=1 at any edge forces IDLE and clears everything, including mid-CALC or in DONE; any pending product is discarded, no out_valid pulse.
  - Outputs while rst=1: in_ready=0, out_valid=0, busy=0, product=0.
  - First cycle after rst deasserts: in_ready=1.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: latch operands and go to CALC with step counter=0.
  - Latch the multiplicand as WIDTH+2 bits, sign-extended if is_signed, else zero-extended.
  - Latch the multiplier as WIDTH+2 bits, extended the same way, with an appended 0 below LSB.
  - Clear the accumulator.
- CALC:
  - in_ready=0. One step per edge.
  - Recode the low 3 bits of the multiplier window into a digit in {-2,-1,0,+1,+2}: 000/111→0, 001/010→+1, 011→+2, 100→-2, 101/110→-1.
  - Add digit×multiplicand, shifted left by 2×counter, into the 2*WIDTH+4-bit accumulator; negation is two's complement.
  - Arithmetic-shift the window right by 2 and increment the counter.
  - After STEPS steps go to DONE; product = accumulator[2*WIDTH-1:0].
- DONE:
  - out_valid=1; product is stable while out_valid=1 and out_ready=0.
  - On out_ready=1 go to IDLE; out_valid falls next cycle.
- Latency: out_valid rises exactly STEPS cycles after the accepting edge (5 for WIDTH=8, 9 for WIDTH=16). Throughput: one result per STEPS+2 cycles with out_ready held high.
- Handshake rules:
  - in_valid while not in IDLE is ignored; no queuing.
  - Operand or is_signed changes after acceptance have no effect.
  - Product is 0 outside DONE.
- Boundary conditions:
  - Signed most-negative × most-negative is exact, e.g. 0x80×0x80 = 0x4000.
  - Unsigned all-ones operands use the extra digit from the 2-bit extension.
  - a=0 or b=0 yields 0 with the same latency; no early termination.

Test Plan:
- WIDTH=8, signed, a=0x15, b=0xAF -> out_valid 5 cycles after accept, product=0xF95B (21×-81). Also a=0xB5, b=0x2E -> 0xF286.
- WIDTH=8, unsigned, a=0xFF, b=0xFF -> 0xFE01. Same operands signed -> 0x0001. Signed a=0x80, b=0x80 -> 0x4000.
- Backpressure, WIDTH=8 signed a=0x15, b=0xAF: hold out_ready=0 for 10 cycles -> out_valid stays 1 and product stays 0xF95B; in_ready stays 0. A second in_valid pulse during the hold is ignored. Raise out_ready -> IDLE, in_ready=1 the next cycle.
- Reset mid-operation: accept a=0x7F, b=0x7F, assert rst in the 3rd CALC cycle -> the next cycle shows busy=0, out_valid=0, product=0. A fresh a=0x03, b=0xFD signed -> 0xFFF7.
- WIDTH=16 instance, signed, a=0x8000, b=0x7FFF -> product=0xC0008000 after 9 cycles. Unsigned a=0xFFFF, b=0x0002 -> 0x0001FFFE.
- Random sweep: 1000 random a/b/is_signed with random out_ready stalls, compared against a behavioural reference -> zero mismatches, latency always STEPS.
